ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
Parametrised multi-cycle control sequencer for the 32-bit bus processor; drives all datapath selects, loads, ALU ops and memory strobes from IR.
Generalises the fixed-timing controller in three ways:
- encoded output groups replace individual strobes;
- memory and MUL/DIV use ready/done handshakes with wait states;
- adds halt/resume, stop-after-instruction and illegal-opcode trap.

Parameters:
IR_WIDTH, 32, instruction register width
OPC_WIDTH, 5, opcode field = IR[IR_WIDTH-1 -: OPC_WIDTH]
MEM_HS, 1, 1: Read/Write held until Mem_ready; 0: Mem_ready ignored, accesses take 1 cycle
MULDIV_MULTI, 1, 1: MUL/DIV wait for Alu_done; 0: fixed 1 cycle

Ports:
Clock  in  1  rising-edge clock
Reset_n  in  1  asynchronous, active-low reset
IR  in  IR_WIDTH  instruction register contents
Con_ff  in  1  branch condition flag
Mem_ready  in  1  memory access complete this cycle
Alu_done  in  1  MUL/DIV result valid this cycle
Stop  in  1  halt after the current instruction
Resume  in  1  leave HALT
Reg_sel  out  2  0 link(R15), 1 Ra, 2 Rb, 3 Rc
Bus_src  out  4  0 none, 1 R, 2 BA, 3 PC, 4 MDR, 5 Zlo, 6 Zhi, 7 C, 8 InPort, 9 HI, 10 LO
Ld  out  11  one-hot-capable loads: [0]R [1]MAR [2]PC [3]MDR [4]IR [5]Y [6]Z [7]HI [8]LO [9]CON [10]OutPort
Alu_op  out  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SHR, 6 SHL, 7 ROR, 8 ROL, 9 MUL, 10 DIV, 11 NEG, 12 NOT, 13 INC
Alu_start  out  1  one-cycle MUL/DIV start pulse
Read  out  1  memory read; MDR loads from memory when Read & Ld[3]
Write  out  1  memory write
Halted  out  1  in HALT state
Illegal  out  1  one-cycle pulse on undefined opcode
State_dbg  out  6  current state code

Behaviour:
- Reset_n=0: state RST; every output 0 immediately, regardless of Clock or an instruction in progress. RST->T0 on the first edge after release.
- Outputs decode from state, plus Mem_ready/Alu_done where stated. Unlisted signals are 0 in each state.

Fetch:
- T0: Bus=PC, Ld MAR, Ld Z, Alu=INC.
- T1: Bus=Zlo, Ld PC, Read, Ld MDR=Mem_ready.
- T1W: Read, Ld MDR=Mem_ready. T1 and T1W go to T2 when Mem_ready, else T1W.
- T2: Bus=MDR, Ld IR.
- DEC: nothing asserted; branch on opcode.
- With zero wait, fetch+decode takes 4 cycles.

Execute classes (one state per bullet):
- ALU3 (add/sub/and/or/shr/shl/ror/rol): Rb->Y; Rc on bus, op, Ld Z; Zlo->Ra.
- MULDIV: Ra->Y; Rb on bus, op, Alu_start.
  - MW holds Rb/op; Ld Z=Alu_done; exit on Alu_done.
  - Then Zlo->LO; Zhi->HI.
  - Alu_done high in the start cycle skips MW.
- NEG/NOT: Rb on bus, op, Ld Z; Zlo->Ra.
- ADDI/ANDI/ORI: Rb->Y; C on bus, op, Ld Z; Zlo->Ra.
- LD/LDI/ST common steps: Rb via BA->Y; C, ADD, Ld Z.
  - LDI: Zlo->Ra.
  - LD: Zlo->MAR; Read, Ld MDR=Mem_ready, waits; MDR->Ra.
  - ST: Zlo->MAR; Ra->MDR; Write, held until Mem_ready.
- BR: Ra->CON; PC->Y; C, ADD, Ld Z; if Con_ff then Zlo->PC, else nothing asserted.
- JR: Ra->PC.
- JAL: PC->R15 (Reg_sel=0, Ld R); Ra->PC.
- MFHI/MFLO: HI/LO->Ra.
- IN: InPort->Ra.
- OUT: Ra->OutPort.
- HALT (11010): HLT.

Sequencing, stop and halt:
- The final state of every class goes to T0, or to HLT if Stop=1 at that edge.
- HLT: Halted=1; stays until Resume=1, then T0. Resume outside HLT is ignored.
- Undefined opcode: ILL state, 1 cycle, Illegal=1, then T0. PC already advanced.
- MEM_HS=0: wait states never entered.
- MULDIV_MULTI=0: MW never entered and Alu_start stays 0.

Test Plan:
- Reset_n low mid-LD (state in wait) -> all outputs 0 same cycle; after release T0 asserts Bus=3, Ld[1], Ld[6], Alu=13.
- add IR=0x18000000|fields, Mem_ready=1 -> exactly 7 cycles T0..Zlo->Ra; state 3 of execute shows Bus=5, Reg_sel=1, Ld[0].
- LD with Mem_ready delayed 3 cycles in fetch and data phase -> T1W held 3 cycles with Read=1; MDR load only in the Mem_ready cycle; MDR->Ra follows.
- MUL with Alu_done at cycle 5 of MW -> Alu_start is a single pulse; Ld Z only in the done cycle; LO then HI loads.
- BR with Con_ff=0 -> final state has Ld[2]=0; with Con_ff=1 -> Bus=5, Ld[2]=1.
- Opcode 11111 -> Illegal pulse of 1 cycle, back to T0. HALT -> Halted held 10 cycles, Resume pulse -> T0. Stop=1 during add -> HLT after add's last state.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - multi-cycle control sequencer for the 32-bit bus processor
// Outputs decode from the current state, plus Mem_ready/Alu_done in the wait-capable states.
module ctrl_sequencer #(
  parameter int IR_WIDTH     = 32,
  parameter int OPC_WIDTH    = 5,
  parameter bit MEM_HS       = 1'b1,
  parameter bit MULDIV_MULTI = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [IR_WIDTH-1:0] IR,
  input  logic                Con_ff,
  input  logic                Mem_ready,
  input  logic                Alu_done,
  input  logic                Stop,
  input  logic                Resume,
  output logic [1:0]          Reg_sel,
  output logic [3:0]          Bus_src,
  output logic [10:0]         Ld,
  output logic [3:0]          Alu_op,
  output logic                Alu_start,
  output logic                Read,
  output logic                Write,
  output logic                Halted,
  output logic                Illegal,
  output logic [5:0]          State_dbg
);

  typedef enum logic [5:0] {
    S_RST, S_T0, S_T1, S_T1W, S_T2, S_DEC,
    S_A3_Y, S_A3_Z, S_A3_R, S_MD_Y, S_MD_S, S_MD_W, S_MD_LO, S_MD_HI,
    S_NN_Z, S_NN_R, S_IM_Y, S_IM_Z, S_IM_R, S_MA_Y, S_MA_Z, S_LDI_R,
    S_LD_MAR, S_LD_RD, S_LD_R, S_ST_MAR, S_ST_MDR, S_ST_WR,
    S_BR_CON, S_BR_Y, S_BR_Z, S_BR_PC, S_JR, S_JAL_LNK, S_JAL_PC,
    S_MFHI, S_MFLO, S_IN, S_OUT, S_HLT, S_ILL
  } state_t;

  localparam logic [4:0] OP_LD = 5'd0, OP_LDI = 5'd1, OP_ST = 5'd2, OP_ADD = 5'd3,
    OP_SUB = 5'd4, OP_AND = 5'd5, OP_OR = 5'd6, OP_SHR = 5'd7, OP_SHL = 5'd8,
    OP_ROR = 5'd9, OP_ROL = 5'd10, OP_ADDI = 5'd11, OP_ANDI = 5'd12, OP_ORI = 5'd13,
    OP_MUL = 5'd14, OP_DIV = 5'd15, OP_NEG = 5'd16, OP_NOT = 5'd17, OP_BR = 5'd18,
    OP_JR = 5'd19, OP_JAL = 5'd20, OP_IN = 5'd21, OP_OUT = 5'd22, OP_MFHI = 5'd23,
    OP_MFLO = 5'd24, OP_HALT = 5'd26;

  localparam logic [1:0] RS_LINK = 2'd0, RS_A = 2'd1, RS_B = 2'd2, RS_C = 2'd3;
  localparam logic [3:0] B_R = 4'd1, B_BA = 4'd2, B_PC = 4'd3, B_MDR = 4'd4, B_ZLO = 4'd5,
    B_ZHI = 4'd6, B_C = 4'd7, B_IN = 4'd8, B_HI = 4'd9, B_LO = 4'd10;
  localparam int L_R = 0, L_MAR = 1, L_PC = 2, L_MDR = 3, L_IR = 4, L_Y = 5, L_Z = 6,
    L_HI = 7, L_LO = 8, L_CON = 9, L_OUT = 10;
  localparam logic [3:0] A_NOP = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_AND = 4'd3, A_OR = 4'd4,
    A_SHR = 4'd5, A_SHL = 4'd6, A_ROR = 4'd7, A_ROL = 4'd8, A_MUL = 4'd9, A_DIV = 4'd10,
    A_NEG = 4'd11, A_NOT = 4'd12, A_INC = 4'd13;

  state_t     state, nxt;
  logic [4:0] opc;
  logic [3:0] op_alu;
  logic       mem_ok, md_ok, last;
  logic       ir_unused;

  assign opc       = 5'(IR[IR_WIDTH-1 -: OPC_WIDTH]);
  assign ir_unused = ^IR[IR_WIDTH-OPC_WIDTH-1:0];
  // With handshakes disabled the access/operation always completes in its first cycle.
  assign mem_ok    = MEM_HS ? Mem_ready : 1'b1;
  assign md_ok     = MULDIV_MULTI ? Alu_done : 1'b1;
  assign State_dbg = state;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) state <= S_RST;
    else          state <= nxt;
  end

  always_comb begin
    op_alu = A_NOP;
    case (opc)
      OP_ADD, OP_ADDI: op_alu = A_ADD;
      OP_SUB:          op_alu = A_SUB;
      OP_AND, OP_ANDI: op_alu = A_AND;
      OP_OR, OP_ORI:   op_alu = A_OR;
      OP_SHR:          op_alu = A_SHR;
      OP_SHL:          op_alu = A_SHL;
      OP_ROR:          op_alu = A_ROR;
      OP_ROL:          op_alu = A_ROL;
      OP_MUL:          op_alu = A_MUL;
      OP_DIV:          op_alu = A_DIV;
      OP_NEG:          op_alu = A_NEG;
      OP_NOT:          op_alu = A_NOT;
      default:         op_alu = A_NOP;
    endcase
  end

  always_comb begin
    nxt = state; last = 1'b0;
    Reg_sel = RS_LINK; Bus_src = 4'd0; Ld = '0; Alu_op = A_NOP;
    Alu_start = 1'b0; Read = 1'b0; Write = 1'b0; Halted = 1'b0; Illegal = 1'b0;
    case (state)
      S_RST: nxt = S_T0;
      S_T0:  begin Bus_src = B_PC; Ld[L_MAR] = 1'b1; Ld[L_Z] = 1'b1; Alu_op = A_INC; nxt = S_T1; end
      S_T1:  begin Bus_src = B_ZLO; Ld[L_PC] = 1'b1; Read = 1'b1; Ld[L_MDR] = mem_ok;
                   nxt = mem_ok ? S_T2 : S_T1W; end
      S_T1W: begin Read = 1'b1; Ld[L_MDR] = mem_ok; nxt = mem_ok ? S_T2 : S_T1W; end
      S_T2:  begin Bus_src = B_MDR; Ld[L_IR] = 1'b1; nxt = S_DEC; end
      S_DEC: begin
        case (opc)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: nxt = S_A3_Y;
          OP_ADDI, OP_ANDI, OP_ORI: nxt = S_IM_Y;
          OP_LD, OP_LDI, OP_ST:     nxt = S_MA_Y;
          OP_MUL, OP_DIV:           nxt = S_MD_Y;
          OP_NEG, OP_NOT:           nxt = S_NN_Z;
          OP_BR:   nxt = S_BR_CON;
          OP_JR:   nxt = S_JR;
          OP_JAL:  nxt = S_JAL_LNK;
          OP_MFHI: nxt = S_MFHI;
          OP_MFLO: nxt = S_MFLO;
          OP_IN:   nxt = S_IN;
          OP_OUT:  nxt = S_OUT;
          OP_HALT: nxt = S_HLT;
          default: nxt = S_ILL;
        endcase
      end
      S_A3_Y:   begin Reg_sel = RS_B; Bus_src = B_R; Ld[L_Y] = 1'b1; nxt = S_A3_Z; end
      S_A3_Z:   begin Reg_sel = RS_C; Bus_src = B_R; Alu_op = op_alu; Ld[L_Z] = 1'b1; nxt = S_A3_R; end
      S_A3_R, S_NN_R, S_IM_R, S_LDI_R:
                begin Reg_sel = RS_A; Bus_src = B_ZLO; Ld[L_R] = 1'b1; last = 1'b1; end
      S_MD_Y:   begin Reg_sel = RS_A; Bus_src = B_R; Ld[L_Y] = 1'b1; nxt = S_MD_S; end
      S_MD_S:   begin Reg_sel = RS_B; Bus_src = B_R; Alu_op = op_alu; Alu_start = MULDIV_MULTI;
                      Ld[L_Z] = md_ok; nxt = md_ok ? S_MD_LO : S_MD_W; end
      S_MD_W:   begin Reg_sel = RS_B; Bus_src = B_R; Alu_op = op_alu; Ld[L_Z] = Alu_done;
                      nxt = Alu_done ? S_MD_LO : S_MD_W; end
      S_MD_LO:  begin Bus_src = B_ZLO; Ld[L_LO] = 1'b1; nxt = S_MD_HI; end
      S_MD_HI:  begin Bus_src = B_ZHI; Ld[L_HI] = 1'b1; last = 1'b1; end
      S_NN_Z:   begin Reg_sel = RS_B; Bus_src = B_R; Alu_op = op_alu; Ld[L_Z] = 1'b1; nxt = S_NN_R; end
      S_IM_Y:   begin Reg_sel = RS_B; Bus_src = B_R; Ld[L_Y] = 1'b1; nxt = S_IM_Z; end
      S_IM_Z:   begin Bus_src = B_C; Alu_op = op_alu; Ld[L_Z] = 1'b1; nxt = S_IM_R; end
      S_MA_Y:   begin Reg_sel = RS_B; Bus_src = B_BA; Ld[L_Y] = 1'b1; nxt = S_MA_Z; end
      S_MA_Z:   begin Bus_src = B_C; Alu_op = A_ADD; Ld[L_Z] = 1'b1;
                      nxt = (opc == OP_LD) ? S_LD_MAR : (opc == OP_LDI) ? S_LDI_R : S_ST_MAR; end
      S_LD_MAR: begin Bus_src = B_ZLO; Ld[L_MAR] = 1'b1; nxt = S_LD_RD; end
      S_LD_RD:  begin Read = 1'b1; Ld[L_MDR] = mem_ok; nxt = mem_ok ? S_LD_R : S_LD_RD; end
      S_LD_R:   begin Reg_sel = RS_A; Bus_src = B_MDR; Ld[L_R] = 1'b1; last = 1'b1; end
      S_ST_MAR: begin Bus_src = B_ZLO; Ld[L_MAR] = 1'b1; nxt = S_ST_MDR; end
      S_ST_MDR: begin Reg_sel = RS_A; Bus_src = B_R; Ld[L_MDR] = 1'b1; nxt = S_ST_WR; end
      S_ST_WR:  begin Write = 1'b1; last = mem_ok; end
      S_BR_CON: begin Reg_sel = RS_A; Bus_src = B_R; Ld[L_CON] = 1'b1; nxt = S_BR_Y; end
      S_BR_Y:   begin Bus_src = B_PC; Ld[L_Y] = 1'b1; nxt = S_BR_Z; end
      S_BR_Z:   begin Bus_src = B_C; Alu_op = A_ADD; Ld[L_Z] = 1'b1; nxt = S_BR_PC; end
      S_BR_PC:  begin if (Con_ff) begin Bus_src = B_ZLO; Ld[L_PC] = 1'b1; end last = 1'b1; end
      S_JR, S_JAL_PC:
                begin Reg_sel = RS_A; Bus_src = B_R; Ld[L_PC] = 1'b1; last = 1'b1; end
      S_JAL_LNK: begin Reg_sel = RS_LINK; Bus_src = B_PC; Ld[L_R] = 1'b1; nxt = S_JAL_PC; end
      S_MFHI:   begin Reg_sel = RS_A; Bus_src = B_HI; Ld[L_R] = 1'b1; last = 1'b1; end
      S_MFLO:   begin Reg_sel = RS_A; Bus_src = B_LO; Ld[L_R] = 1'b1; last = 1'b1; end
      S_IN:     begin Reg_sel = RS_A; Bus_src = B_IN; Ld[L_R] = 1'b1; last = 1'b1; end
      S_OUT:    begin Reg_sel = RS_A; Bus_src = B_R; Ld[L_OUT] = 1'b1; last = 1'b1; end
      S_HLT:    begin Halted = 1'b1; if (Resume) nxt = S_T0; end
      S_ILL:    begin Illegal = 1'b1; nxt = S_T0; end
      default:  nxt = S_RST;
    endcase
    // Every class funnels through here so Stop is honoured only at instruction boundaries.
    if (last) nxt = Stop ? S_HLT : S_T0;
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - self-checking bench for ctrl_sequencer
// Reference model is a per-instruction queue of micro-steps built from each opcode's step list.
module tb_ctrl_sequencer;
  logic        Clock = 1'b0, Reset_n = 1'b0;
  logic [31:0] IR = '0, ir_nx = '0;
  logic        Con_ff = 1'b0, Mem_ready = 1'b0, Alu_done = 1'b0, Stop = 1'b0, Resume = 1'b0;
  logic [1:0]  Reg_sel;
  logic [3:0]  Bus_src, Alu_op;
  logic [10:0] Ld;
  logic        Alu_start, Read, Write, Halted, Illegal;
  logic [5:0]  State_dbg;
  int          n_cmp = 0, n_bad = 0;

  ctrl_sequencer dut (.Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Con_ff(Con_ff),
    .Mem_ready(Mem_ready), .Alu_done(Alu_done), .Stop(Stop), .Resume(Resume),
    .Reg_sel(Reg_sel), .Bus_src(Bus_src), .Ld(Ld), .Alu_op(Alu_op), .Alu_start(Alu_start),
    .Read(Read), .Write(Write), .Halted(Halted), .Illegal(Illegal), .State_dbg(State_dbg));

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [1:0] rs; logic [3:0] bus; logic [10:0] ld; logic [3:0] alu;
    logic st, rd, wr, hl, il;
  } outv_t;
  typedef struct { outv_t o; int kind; bit fin; bit t0; } step_t;
  typedef struct { int opc; bit con; int ncyc; outv_t fin; } vec_t;

  localparam int K_PL = 0, K_RD = 1, K_WR = 2, K_MD = 3, K_BR = 4, K_DEC = 5;
  localparam int M_RST = 0, M_RUN = 1, M_HLT = 2;
  localparam logic [10:0] LR = 11'h001, LMAR = 11'h002, LPC = 11'h004, LMDR = 11'h008,
    LIR = 11'h010, LY = 11'h020, LZ = 11'h040, LHI = 11'h080, LLO = 11'h100,
    LCON = 11'h200, LOUT = 11'h400;

  step_t q[$];
  int    m_mode = M_RST;
  outv_t act, t0sig;
  vec_t  tab[$];

  function automatic outv_t mk(input int rs, input int bus, input logic [10:0] ld, input int alu);
    outv_t o;
    o = '0; o.rs = 2'(rs); o.bus = 4'(bus); o.ld = ld; o.alu = 4'(alu);
    return o;
  endfunction

  function automatic outv_t cur();
    return {Reg_sel, Bus_src, Ld, Alu_op, Alu_start, Read, Write, Halted, Illegal};
  endfunction

  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic push(input outv_t o, input int kind = K_PL, input bit fin = 1'b0);
    step_t s;
    s.o = o; s.kind = kind; s.fin = fin; s.t0 = 1'b0;
    q.push_back(s);
  endtask

  task automatic push_fetch();
    outv_t o;
    push(mk(0, 3, LMAR | LZ, 13));
    q[q.size()-1].t0 = 1'b1;
    o = mk(0, 5, LPC, 0); o.rd = 1'b1;
    push(o, K_RD);
    push(mk(0, 4, LIR, 0));
    push('0, K_DEC);
  endtask

  task automatic push_exec(input int opc);
    outv_t o, zra;
    zra = mk(1, 5, LR, 0);
    if (opc >= 3 && opc <= 10) begin
      push(mk(2, 1, LY, 0)); push(mk(3, 1, LZ, opc - 2)); push(zra, K_PL, 1);
    end else if (opc >= 11 && opc <= 13) begin
      push(mk(2, 1, LY, 0)); push(mk(0, 7, LZ, (opc == 11) ? 1 : (opc == 12) ? 3 : 4));
      push(zra, K_PL, 1);
    end else if (opc == 14 || opc == 15) begin
      push(mk(1, 1, LY, 0));
      o = mk(2, 1, 11'h0, opc - 5); o.st = 1'b1; push(o, K_MD);
      push(mk(0, 5, LLO, 0)); push(mk(0, 6, LHI, 0), K_PL, 1);
    end else if (opc == 16 || opc == 17) begin
      push(mk(2, 1, LZ, opc - 5)); push(zra, K_PL, 1);
    end else if (opc <= 2) begin
      push(mk(2, 2, LY, 0)); push(mk(0, 7, LZ, 1));
      if (opc == 1) push(zra, K_PL, 1);
      else if (opc == 0) begin
        push(mk(0, 5, LMAR, 0)); o = '0; o.rd = 1'b1; push(o, K_RD); push(mk(1, 4, LR, 0), K_PL, 1);
      end else begin
        push(mk(0, 5, LMAR, 0)); push(mk(1, 1, LMDR, 0)); o = '0; o.wr = 1'b1; push(o, K_WR, 1);
      end
    end else if (opc == 18) begin
      push(mk(1, 1, LCON, 0)); push(mk(0, 3, LY, 0)); push(mk(0, 7, LZ, 1)); push('0, K_BR, 1);
    end else if (opc == 19) push(mk(1, 1, LPC, 0), K_PL, 1);
    else if (opc == 20) begin push(mk(0, 3, LR, 0)); push(mk(1, 1, LPC, 0), K_PL, 1); end
    else if (opc == 21) push(mk(1, 8, LR, 0), K_PL, 1);
    else if (opc == 22) push(mk(1, 1, LOUT, 0), K_PL, 1);
    else if (opc == 23) push(mk(1, 9, LR, 0), K_PL, 1);
    else if (opc == 24) push(mk(1, 10, LR, 0), K_PL, 1);
    else if (opc == 26) m_mode = M_HLT;
    else begin o = '0; o.il = 1'b1; push(o); end
  endtask

  function automatic outv_t model_out(input logic mr, input logic ad, input logic con);
    outv_t o;
    o = '0;
    if (m_mode == M_HLT) o.hl = 1'b1;
    else if (m_mode == M_RUN) begin
      o = q[0].o;
      if (q[0].kind == K_RD) o.ld[3] = mr;
      if (q[0].kind == K_MD) o.ld[6] = ad;
      if (q[0].kind == K_BR && con) begin o.bus = 4'd5; o.ld[2] = 1'b1; end
    end
    return o;
  endfunction

  task automatic model_edge(input logic mr, input logic ad, input logic stp, input logic res);
    step_t s;
    logic  done;
    if (!Reset_n) begin m_mode = M_RST; q.delete(); return; end
    if (m_mode == M_RST) begin m_mode = M_RUN; push_fetch(); return; end
    if (m_mode == M_HLT) begin
      if (res) begin m_mode = M_RUN; push_fetch(); end
      return;
    end
    s = q[0];
    done = 1'b1;
    if (s.kind == K_RD || s.kind == K_WR) done = mr;
    if (s.kind == K_MD) done = ad;
    if (!done) begin
      // Fetch's PC load and the MUL/DIV start pulse belong only to the first cycle of a wait.
      q[0].o.ld[2] = 1'b0;
      if (s.kind == K_RD) q[0].o.bus = 4'd0;
      q[0].o.st = 1'b0;
    end else begin
      void'(q.pop_front());
      if (s.kind == K_DEC) push_exec(int'(IR[31:27]));
      if (q.size() == 0 && m_mode == M_RUN) begin
        if (s.fin && stp) m_mode = M_HLT;
        else push_fetch();
      end
    end
  endtask

  function automatic bit at_t0();
    return m_mode == M_RUN && q.size() > 0 && q[0].t0;
  endfunction

  task automatic cyc(input logic mr, input logic ad, input logic con, input logic stp, input logic res);
    @(negedge Clock);
    IR = ir_nx; Mem_ready = mr; Alu_done = ad; Con_ff = con; Stop = stp; Resume = res;
    #1;
    act = cur();
    check("cycle", act, model_out(mr, ad, con));
    @(posedge Clock);
    model_edge(mr, ad, stp, res);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int n, reads, mdrs, pcs, starts, ldzs, hls, ils;
    bit hit;
    outv_t o, lastv;
    t0sig = mk(0, 3, LMAR | LZ, 13);

    tab.push_back('{3, 0, 7, mk(1, 5, LR, 0)});
    tab.push_back('{8, 0, 7, mk(1, 5, LR, 0)});
    tab.push_back('{11, 0, 7, mk(1, 5, LR, 0)});
    tab.push_back('{16, 0, 6, mk(1, 5, LR, 0)});
    tab.push_back('{1, 0, 7, mk(1, 5, LR, 0)});
    tab.push_back('{0, 0, 9, mk(1, 4, LR, 0)});
    o = '0; o.wr = 1'b1;
    tab.push_back('{2, 0, 9, o});
    tab.push_back('{14, 0, 8, mk(0, 6, LHI, 0)});
    tab.push_back('{18, 0, 8, mk(0, 0, 11'h0, 0)});
    tab.push_back('{18, 1, 8, mk(0, 5, LPC, 0)});
    tab.push_back('{19, 0, 5, mk(1, 1, LPC, 0)});
    tab.push_back('{20, 0, 6, mk(1, 1, LPC, 0)});
    tab.push_back('{23, 0, 5, mk(1, 9, LR, 0)});
    tab.push_back('{21, 0, 5, mk(1, 8, LR, 0)});
    tab.push_back('{22, 0, 5, mk(1, 1, LOUT, 0)});
    o = '0; o.il = 1'b1;
    tab.push_back('{31, 0, 5, o});

    // Reset and release
    Reset_n = 1'b0;
    cyc(1, 1, 0, 0, 0);
    check("reset_outputs", {act, State_dbg}, '0);
    cyc(1, 1, 0, 0, 0);
    #2 Reset_n = 1'b1;
    cyc(1, 1, 0, 0, 0);
    #1 check("t0_after_reset", cur(), t0sig);

    foreach (tab[i]) begin
      ir_nx = {5'(tab[i].opc), 27'($urandom)};
      n = 0; hit = 1'b0; lastv = '0;
      while (!hit && n < 40) begin
        cyc(1, 1, tab[i].con, 0, 0);
        n++; lastv = act;
        #1 hit = (cur() == t0sig);
      end
      check($sformatf("cycles_op%0d_c%0d", tab[i].opc, tab[i].con), 32'(n), 32'(tab[i].ncyc));
      check($sformatf("final_op%0d_c%0d", tab[i].opc, tab[i].con), lastv, tab[i].fin);
    end

    // LD with three wait cycles in both fetch and data phase
    ir_nx = {5'd0, 27'h0123456};
    cyc(1, 1, 0, 0, 0);
    reads = 0; mdrs = 0; pcs = 0;
    cyc(0, 1, 0, 0, 0); reads += int'(act.rd); mdrs += int'(act.ld[3]); pcs += int'(act.ld[2]);
    for (int k = 0; k < 3; k++) begin
      cyc(k == 2, 1, 0, 0, 0); reads += int'(act.rd); mdrs += int'(act.ld[3]); pcs += int'(act.ld[2]);
    end
    check("fetch_wait_reads", 32'(reads), 32'd4);
    check("fetch_wait_mdr_loads", 32'(mdrs), 32'd1);
    check("fetch_wait_pc_loads", 32'(pcs), 32'd1);
    repeat (5) cyc(1, 1, 0, 0, 0);
    reads = 0; mdrs = 0;
    for (int k = 0; k < 4; k++) begin
      cyc(k == 3, 1, 0, 0, 0); reads += int'(act.rd); mdrs += int'(act.ld[3]);
    end
    check("data_wait_reads", 32'(reads), 32'd4);
    check("data_wait_mdr_loads", 32'(mdrs), 32'd1);
    cyc(1, 1, 0, 0, 0);
    check("mdr_to_ra", {act.rs, act.bus, act.ld}, {2'd1, 4'd4, LR});

    // MUL with Alu_done on the fifth wait cycle
    ir_nx = {5'd14, 27'h0456789};
    repeat (4) cyc(1, 0, 0, 0, 0);
    starts = 0; ldzs = 0;
    for (int k = 0; k < 7; k++) begin
      cyc(1, k == 6, 0, 0, 0); starts += int'(act.st); ldzs += int'(act.ld[6]);
    end
    check("mul_start_pulses", 32'(starts), 32'd1);
    check("mul_ldz_count", 32'(ldzs), 32'd1);
    cyc(1, 0, 0, 0, 0);
    check("mul_lo_load", {act.bus, act.ld}, {4'd5, LLO});
    cyc(1, 0, 0, 0, 0);
    check("mul_hi_load", {act.bus, act.ld}, {4'd6, LHI});

    // Stop during add, then hold HLT for 10 cycles and resume
    ir_nx = {5'd3, 27'h0ABCDEF};
    repeat (7) cyc(1, 1, 0, 1, 0);
    hls = 0;
    repeat (10) begin cyc(1, 1, 0, 0, 0); hls += int'(act.hl); end
    check("halt_held", 32'(hls), 32'd10);
    cyc(1, 1, 0, 0, 1);
    #1 check("resume_to_t0", cur(), t0sig);

    // HALT opcode
    ir_nx = {5'd26, 27'h0};
    repeat (4) cyc(1, 1, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    check("halt_opcode", 32'(act.hl), 32'd1);
    cyc(1, 1, 0, 0, 1);
    #1 check("halt_resume_t0", cur(), t0sig);

    // Illegal opcode
    ir_nx = {5'd31, 27'h0};
    ils = 0;
    repeat (5) begin cyc(1, 1, 0, 0, 0); ils += int'(act.il); end
    check("illegal_pulse", 32'(ils), 32'd1);
    #1 check("ill_to_t0", cur(), t0sig);

    // Asynchronous reset while LD waits for memory
    ir_nx = {5'd0, 27'h0000042};
    repeat (7) cyc(1, 1, 0, 0, 0);
    repeat (2) cyc(0, 1, 0, 0, 0);
    check("ld_wait_read", 32'(act.rd), 32'd1);
    @(negedge Clock);
    #3 Reset_n = 1'b0;
    #1 check("async_reset_outputs", {cur(), State_dbg}, '0);
    m_mode = M_RST; q.delete();
    @(posedge Clock);
    cyc(1, 1, 0, 0, 0);
    #2 Reset_n = 1'b1;
    cyc(1, 1, 0, 0, 0);
    #1 check("t0_after_midld_reset", cur(), t0sig);

    // Random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if (at_t0()) ir_nx = $urandom;
      cyc(($urandom % 3) != 0, ($urandom % 3) == 0, $urandom % 2,
          ($urandom % 8) == 0, ($urandom % 6) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
